lighting_multi: RTL and testbench

Sequential successor to the single-light combinational lighting stage. It lights one vertex colour against a table of `NUM_LIGHTS` directional lights, one light per clock, with ambient and diffuse coefficients supplied per vertex. It saturates the summed light intensity to 1.0 and delivers the lit colour over a valid/ready handshake. It sits between vertex transform (world-space normal available) and rasteriser setup.

---
 rtl/lighting_multi_pkg.sv | 79 +++++++
 rtl/lighting_multi_light.sv | 37 +++
 rtl/lighting_multi.sv | 106 ++++++++++
 tb/tb_lighting_multi.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lighting_multi_pkg.sv
// Shared Q16.16 fixed-point vector types and saturating arithmetic helpers
// used by the multi-light lighting stage.
package lighting_multi_pkg;

    localparam int FP_FRAC = 16;

    typedef logic signed [31:0] FixedPoint_t;

    typedef struct packed {
        FixedPoint_t x;
        FixedPoint_t y;
        FixedPoint_t z;
        FixedPoint_t w;
    } Vector4_t;

    localparam FixedPoint_t FIXED_ONE = 32'sh0001_0000;
    localparam FixedPoint_t FIXED_MAX = 32'sh7FFF_FFFF;
    localparam FixedPoint_t FIXED_MIN = 32'sh8000_0000;

    function automatic FixedPoint_t fp_sat(input logic signed [63:0] v);
        if (v > 64'sd2147483647)  return FIXED_MAX;
        if (v < -64'sd2147483648) return FIXED_MIN;
        return v[31:0];
    endfunction

    function automatic FixedPoint_t fp_add(input FixedPoint_t a, input FixedPoint_t b);
        logic signed [63:0] ea, eb;
        ea = a;
        eb = b;
        return fp_sat(ea + eb);
    endfunction

    function automatic FixedPoint_t fp_sub(input FixedPoint_t a, input FixedPoint_t b);
        logic signed [63:0] ea, eb;
        ea = a;
        eb = b;
        return fp_sat(ea - eb);
    endfunction

    function automatic FixedPoint_t fp_mul(input FixedPoint_t a, input FixedPoint_t b);
        logic signed [63:0] ea, eb, p;
        ea = a;
        eb = b;
        p  = ea * eb;
        return fp_sat(p >>> FP_FRAC);
    endfunction

    function automatic FixedPoint_t fp_max(input FixedPoint_t a, input FixedPoint_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic FixedPoint_t fp_min(input FixedPoint_t a, input FixedPoint_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic FixedPoint_t fp_dot(input Vector4_t a, input Vector4_t b);
        return fp_add(fp_add(fp_mul(a.x, b.x), fp_mul(a.y, b.y)),
                      fp_add(fp_mul(a.z, b.z), fp_mul(a.w, b.w)));
    endfunction

    function automatic Vector4_t vec_neg(input Vector4_t v);
        Vector4_t r;
        r.x = fp_sub('0, v.x);
        r.y = fp_sub('0, v.y);
        r.z = fp_sub('0, v.z);
        r.w = fp_sub('0, v.w);
        return r;
    endfunction

    function automatic Vector4_t vec_scale(input Vector4_t v, input FixedPoint_t s);
        Vector4_t r;
        r.x = fp_mul(v.x, s);
        r.y = fp_mul(v.y, s);
        r.z = fp_mul(v.z, s);
        r.w = fp_mul(v.w, s);
        return r;
    endfunction

endpackage

// File: rtl/lighting_multi_light.sv
// Light table: register file of {direction, enable} with one write port,
// one combinational read port and synchronous clear.
module lighting_light_table
    import lighting_multi_pkg::*;
#(
    parameter int NUM_LIGHTS        = 4,
    parameter int LIGHT_INDEX_WIDTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_we,
    input  logic [LIGHT_INDEX_WIDTH-1:0] i_widx,
    input  Vector4_t                     i_wdir,
    input  logic                         i_wen,
    input  logic [LIGHT_INDEX_WIDTH-1:0] i_ridx,
    output Vector4_t                     o_rdir,
    output logic                         o_ren
);

    Vector4_t               dir_q [NUM_LIGHTS];
    logic [NUM_LIGHTS-1:0]  en_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_LIGHTS; i++) dir_q[i] <= '0;
            en_q <= '0;
        end else if (i_we && (int'(i_widx) < NUM_LIGHTS)) begin
            dir_q[i_widx] <= i_wdir;
            en_q[i_widx]  <= i_wen;
        end
    end

    // Read sees the pre-edge contents, so a same-cycle write is not observed.
    assign o_rdir = dir_q[i_ridx];
    assign o_ren  = en_q[i_ridx];

endmodule

// File: rtl/lighting_multi.sv
// Lights one vertex against NUM_LIGHTS directional lights, one light per
// clock, then scales the colour by the clamped intensity.
module lighting_multi
    import lighting_multi_pkg::*;
#(
    parameter int NUM_LIGHTS        = 4,
    parameter int LIGHT_INDEX_WIDTH = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  Vector4_t                     i_colour,
    input  Vector4_t                     i_normal,
    input  FixedPoint_t                  i_coeff_ambient,
    input  FixedPoint_t                  i_coeff_diffuse,
    input  logic                         i_light_we,
    input  logic [LIGHT_INDEX_WIDTH-1:0] i_light_index,
    input  Vector4_t                     i_light_direction,
    input  logic                         i_light_enable,
    output logic                         o_valid,
    input  logic                         i_ready,
    output Vector4_t                     o_colour,
    output logic                         o_busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUTPUT} state_t;

    localparam logic [LIGHT_INDEX_WIDTH-1:0] K_LAST = LIGHT_INDEX_WIDTH'(NUM_LIGHTS - 1);

    state_t                         state_q;
    logic [LIGHT_INDEX_WIDTH-1:0]   k_q;
    Vector4_t                       colour_q, normal_q, o_colour_q;
    FixedPoint_t                    amb_q, dif_q, acc_q, acc_d;
    FixedPoint_t                    contrib, intensity;
    logic                           o_valid_q;
    Vector4_t                       tbl_dir;
    logic                           tbl_en;

    lighting_light_table #(
        .NUM_LIGHTS        (NUM_LIGHTS),
        .LIGHT_INDEX_WIDTH (LIGHT_INDEX_WIDTH)
    ) u_table (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (i_light_we),
        .i_widx  (i_light_index),
        .i_wdir  (i_light_direction),
        .i_wen   (i_light_enable),
        .i_ridx  (k_q),
        .o_rdir  (tbl_dir),
        .o_ren   (tbl_en)
    );

    // Light direction is the travel direction, so incidence uses its negation.
    assign contrib   = fp_max('0, fp_dot(normal_q, vec_neg(tbl_dir)));
    assign acc_d     = tbl_en ? fp_add(acc_q, contrib) : acc_q;
    assign intensity = fp_min(FIXED_ONE, fp_add(amb_q, fp_mul(dif_q, acc_q)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            colour_q   <= '0;
            normal_q   <= '0;
            amb_q      <= '0;
            dif_q      <= '0;
            acc_q      <= '0;
            o_valid_q  <= 1'b0;
            o_colour_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_valid) begin
                    colour_q <= i_colour;
                    normal_q <= i_normal;
                    amb_q    <= i_coeff_ambient;
                    dif_q    <= i_coeff_diffuse;
                    acc_q    <= '0;
                    k_q      <= '0;
                    state_q  <= ACCUM;
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    if (k_q == K_LAST) state_q <= SCALE;
                    else               k_q     <= k_q + 1'b1;
                end
                SCALE: begin
                    o_colour_q <= vec_scale(colour_q, intensity);
                    o_valid_q  <= 1'b1;
                    state_q    <= OUTPUT;
                end
                OUTPUT: if (i_ready) begin
                    o_valid_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE) && !i_reset;
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = o_valid_q;
    assign o_colour = o_colour_q;

endmodule

// File: tb/tb_lighting_multi.sv
// Directed self-checking bench for lighting_multi (NUM_LIGHTS=4).
module tb_lighting_multi;
    import lighting_multi_pkg::*;

    localparam int NL = 4;
    localparam FixedPoint_t F1   = 32'sh0001_0000;
    localparam FixedPoint_t F3Q  = 32'sh0000_C000;
    localparam FixedPoint_t F5_8 = 32'sh0000_A000;
    localparam FixedPoint_t FH   = 32'sh0000_8000;
    localparam FixedPoint_t F5_16= 32'sh0000_5000;
    localparam FixedPoint_t FQ   = 32'sh0000_4000;
    localparam FixedPoint_t F5_32= 32'sh0000_2800;
    localparam FixedPoint_t FE   = 32'sh0000_2000;
    localparam FixedPoint_t F16  = 32'sh0000_1000;
    localparam FixedPoint_t FNEG1= -32'sh0001_0000;
    localparam FixedPoint_t FNEGH= -32'sh0000_8000;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_ready, i_light_we, i_light_enable;
    logic        o_ready, o_valid, o_busy;
    logic [1:0]  i_light_index;
    Vector4_t    i_colour, i_normal, i_light_direction, o_colour;
    FixedPoint_t i_coeff_ambient, i_coeff_diffuse;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    lighting_multi #(.NUM_LIGHTS(NL), .LIGHT_INDEX_WIDTH(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_colour(i_colour), .i_normal(i_normal),
        .i_coeff_ambient(i_coeff_ambient), .i_coeff_diffuse(i_coeff_diffuse),
        .i_light_we(i_light_we), .i_light_index(i_light_index),
        .i_light_direction(i_light_direction), .i_light_enable(i_light_enable),
        .o_valid(o_valid), .i_ready(i_ready), .o_colour(o_colour), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic Vector4_t v4(input FixedPoint_t a, b, c, d);
        Vector4_t r;
        r.x = a; r.y = b; r.z = c; r.w = d;
        return r;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_light(input logic [1:0] idx, input Vector4_t dir, input logic en);
        i_light_we = 1'b1; i_light_index = idx; i_light_direction = dir; i_light_enable = en;
        tick();
        i_light_we = 1'b0;
    endtask

    task automatic set_vertex(input Vector4_t c, n, input FixedPoint_t a, d);
        i_colour = c; i_normal = n; i_coeff_ambient = a; i_coeff_diffuse = d;
    endtask

    // Accepts one vertex and waits for o_valid; lat is the edge (after the
    // accept edge) on which downstream first samples o_valid, -1 on timeout.
    task automatic run_vertex(input Vector4_t c, n, input FixedPoint_t a, d,
                              output Vector4_t res, output int lat);
        set_vertex(c, n, a, d);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (o_valid) begin lat = e + 1; break; end
        end
        res = o_colour;
    endtask

    task automatic drain();
        for (int e = 0; e < 30 && o_busy; e++) tick();
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_light_we = 1'b0;
        i_light_index = '0; i_light_direction = '0; i_light_enable = 1'b0;
        set_vertex('0, '0, '0, '0);
        tick(); tick();
        tot_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else pass_cnt++;
        tot_cnt++; if (o_colour !== '0) $display("FAIL reset_colour: got %h want 0", o_colour); else pass_cnt++;
        tot_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
        tot_cnt++; if (o_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", o_ready); else pass_cnt++;
        i_reset = 1'b0;
        #1;
        tot_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready_release: got %b want 1", o_ready); else pass_cnt++;
    endtask

    task automatic test_single_light();
        Vector4_t res; int lat;
        write_light(2'd0, v4(0, 0, FNEG1, 0), 1'b1);
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (lat !== 6) $display("FAIL single_latency: got %0d want 6", lat); else pass_cnt++;
        tot_cnt++; if (res !== v4(F1, FH, FQ, F1)) $display("FAIL single_colour: got %h want %h", res, v4(F1, FH, FQ, F1)); else pass_cnt++;
        tot_cnt++; if (o_ready !== 1'b0) $display("FAIL single_ready_in_output: got %b want 0", o_ready); else pass_cnt++;
        tick();
        tot_cnt++; if (o_valid !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", o_valid); else pass_cnt++;
        tot_cnt++; if (o_ready !== 1'b1) $display("FAIL single_ready_after: got %b want 1", o_ready); else pass_cnt++;
    endtask

    task automatic test_facing_away();
        Vector4_t res; int lat;
        write_light(2'd0, v4(0, 0, F1, 0), 1'b1);
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (res !== v4(FQ, FE, F16, FQ)) $display("FAIL away_colour: got %h want %h", res, v4(FQ, FE, F16, FQ)); else pass_cnt++;
        tick();
    endtask

    task automatic test_clamp();
        Vector4_t res; int lat;
        write_light(2'd0, v4(0, 0, FNEG1, 0), 1'b1);
        write_light(2'd1, v4(0, 0, FNEG1, 0), 1'b1);
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (res !== v4(F1, FH, FQ, F1)) $display("FAIL clamp_175: got %h want %h", res, v4(F1, FH, FQ, F1)); else pass_cnt++;
        tick();
        write_light(2'd0, v4(0, 0, FNEGH, 0), 1'b1);
        write_light(2'd1, v4(0, 0, FNEGH, 0), 1'b1);
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (res !== v4(F1, FH, FQ, F1)) $display("FAIL clamp_exact_one: got %h want %h", res, v4(F1, FH, FQ, F1)); else pass_cnt++;
        tick();
        // One half-incidence light: 0.25 + 0.75*0.5 = 0.625.
        write_light(2'd1, v4(0, 0, FNEGH, 0), 1'b0);
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (res !== v4(F5_8, F5_16, F5_32, F5_8)) $display("FAIL clamp_partial: got %h want %h", res, v4(F5_8, F5_16, F5_32, F5_8)); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        write_light(2'd0, v4(0, 0, FNEG1, 0), 1'b1);
        set_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q);
        i_ready = 1'b1; i_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (o_ready) acc_cyc.push_back(c);
            tick();
        end
        i_valid = 1'b0;
        drain();
        tot_cnt++;
        if (acc_cyc.size() < 2) $display("FAIL b2b_accepts: got %0d want >=2", acc_cyc.size());
        else if (acc_cyc[1] - acc_cyc[0] !== NL + 3) $display("FAIL b2b_interval: got %0d want %0d", acc_cyc[1] - acc_cyc[0], NL + 3);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        Vector4_t res, held; int lat, e;
        write_light(2'd0, v4(0, 0, FNEG1, 0), 1'b1);
        i_ready = 1'b0;
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, held, lat);
        tot_cnt++; if (held !== v4(F1, FH, FQ, F1)) $display("FAIL bp_first_colour: got %h want %h", held, v4(F1, FH, FQ, F1)); else pass_cnt++;
        set_vertex(v4(FH, FH, FH, FH), v4(0, 0, F1, 0), FQ, 0);
        i_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            tot_cnt++;
            if (o_valid !== 1'b1 || o_colour !== held || o_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b c=%h r=%b want v=1 c=%h r=0", c, o_valid, o_colour, o_ready, held);
            else pass_cnt++;
        end
        i_ready = 1'b1;
        tick();
        tot_cnt++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1)
            $display("FAIL bp_handshake: got v=%b b=%b r=%b want 0 0 1", o_valid, o_busy, o_ready); else pass_cnt++;
        tick();
        i_valid = 1'b0;
        tot_cnt++; if (o_busy !== 1'b1) $display("FAIL bp_second_accept: got %b want 1", o_busy); else pass_cnt++;
        for (e = 0; e < 20 && !o_valid; e++) tick();
        res = o_colour;
        tot_cnt++; if (!o_valid || res !== v4(FE, FE, FE, FE)) $display("FAIL bp_second_colour: got v=%b c=%h want %h", o_valid, res, v4(FE, FE, FE, FE)); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_accum();
        Vector4_t res; int lat; int seen;
        write_light(2'd0, v4(0, 0, FNEG1, 0), 1'b1);
        set_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick(); tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        tot_cnt++; if (o_ready !== 1'b1 || o_busy !== 1'b0) $display("FAIL rst_mid_idle: got r=%b b=%b want 1 0", o_ready, o_busy); else pass_cnt++;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid) seen++;
            tick();
        end
        tot_cnt++; if (seen !== 0) $display("FAIL rst_mid_no_output: got %0d valid cycles want 0", seen); else pass_cnt++;
        run_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, F3Q, res, lat);
        tot_cnt++; if (res !== v4(FQ, FE, F16, FQ)) $display("FAIL rst_mid_fresh_table: got %h want %h", res, v4(FQ, FE, F16, FQ)); else pass_cnt++;
        tick();
    endtask

    task automatic test_write_while_busy();
        int e;
        set_vertex(v4(F1, FH, FQ, F1), v4(0, 0, F1, 0), FQ, FH);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        // Entry 1 is written in the cycle it is read; entry 3 before it is reached.
        i_light_we = 1'b1; i_light_index = 2'd1; i_light_direction = v4(0, 0, FNEG1, 0); i_light_enable = 1'b1;
        tick();
        i_light_index = 2'd3;
        tick();
        i_light_we = 1'b0;
        for (e = 0; e < 20 && !o_valid; e++) tick();
        tot_cnt++; if (!o_valid || o_colour !== v4(F3Q, 32'sh6000, 32'sh3000, F3Q))
            $display("FAIL busy_write: got v=%b c=%h want %h", o_valid, o_colour, v4(F3Q, 32'sh6000, 32'sh3000, F3Q));
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_light();
        test_facing_away();
        test_clamp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_accum();
        test_write_while_busy();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
